// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file slave: FSM encoding and register map helpers.
package apb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } apb_state_t;

  localparam int IDX_W     = 6;
  localparam int MAX_REGS  = 64;
  localparam int CNT_W     = 4;

  // The transfer counter always occupies the last slot of the map.
  function automatic int xfer_cnt_idx(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Access-phase wait-state counter: load on setup, count down while the master waits.
module apb_wait_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             s_axi_clk,
  input  logic             s_axi_aresetn,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && !zero) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave exposing NUM_REGS-1 byte-strobed R/W registers plus a read-only transfer counter.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2
) (
  input  logic        s_axi_clk,
  input  logic        s_axi_aresetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  input  logic [2:0]  pprot,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam logic [IDX_W-1:0] XFER_IDX = IDX_W'(xfer_cnt_idx(NUM_REGS));

  apb_state_t state_reg, state_next;
  logic       ctr_load, ctr_dec, ctr_zero;

  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] index;
  logic             wr_commit;
  logic [31:0]      xfer_cnt_reg;
  logic [31:0]      rd_vec [MAX_REGS];
  logic             unused_pprot;

  assign unused_pprot = ^pprot;

  apb_wait_ctr #(
    .WIDTH(CNT_W)
  ) u_wait_ctr (
    .s_axi_clk    (s_axi_clk),
    .s_axi_aresetn(s_axi_aresetn),
    .load         (ctr_load),
    .dec          (ctr_dec),
    .load_val     (CNT_W'(WAIT_STATES)),
    .zero         (ctr_zero)
  );

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    pready     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // psel with penable already high means we missed the setup phase.
        if (psel && !penable) begin
          state_next = ST_WAIT;
          ctr_load   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (penable && ctr_zero) begin
          pready     = 1'b1;
          state_next = ST_IDLE;
        end else if (!psel) begin
          state_next = ST_IDLE;
        end else if (penable) begin
          ctr_dec = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Modular subtraction lets addresses below BASE_ADDR wrap high and miss.
  assign offset    = paddr - BASE_ADDR;
  assign hit       = (paddr[1:0] == 2'b00) && (offset < 32'(4 * NUM_REGS));
  assign index     = offset[7:2];
  assign wr_commit = pready && pwrite && hit && (index != XFER_IDX);

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      xfer_cnt_reg <= '0;
    end else if (pready) begin
      xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REGS; gi++) begin : g_reg
      if (gi < NUM_REGS - 1) begin : g_rw
        logic [31:0] word_reg;
        always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
          if (!s_axi_aresetn) begin
            word_reg <= '0;
          end else if (wr_commit && (index == IDX_W'(gi))) begin
            for (int b = 0; b < 4; b++) begin
              if (pstrb[b]) begin
                word_reg[8*b +: 8] <= pwdata[8*b +: 8];
              end
            end
          end
        end
        assign rd_vec[gi] = word_reg;
      end else if (gi == NUM_REGS - 1) begin : g_cnt
        assign rd_vec[gi] = xfer_cnt_reg;
      end else begin : g_none
        assign rd_vec[gi] = '0;
      end
    end
  endgenerate

  assign prdata  = (pready && !pwrite && hit) ? rd_vec[index] : 32'd0;
  assign pslverr = pready && (!hit || (pwrite && (index == XFER_IDX)));

endmodule
